adc_sample_acq: RTL
===================

// Module: adc_sample_acq
// PURPOSE
//  Upstream front end for the TR tracking stage. Periodically triggers a serial ADC
//  and shifts in one DATA_W-bit sample (MSB first). Presents the sample on x with a
//  one-clk data_valid strobe, so TR can consume x on that strobe. Runs in the 50 MHz clk domain.
// PARAMETERS
//  DATA_W        36   bits per sample; equals the width of x
//  SCLK_DIV      2    adc_sclk half-period, in clk cycles (>=1)
//  CONV_CYCLES   35   adc_cnv high time, in clk cycles (>=1)
//  SAMPLE_PERIOD 250  clk cycles between conversion starts (200 kHz at 50 MHz)
//  Legal only if SAMPLE_PERIOD >= CONV_CYCLES + 2*SCLK_DIV*DATA_W + 2; elaboration fails otherwise.
// PORTS
//  clk         in   1       system clock, 50 MHz
//  rst         in   1       asynchronous reset, active-low
//  enable      in   1       1 = run periodic acquisition
//  adc_sdo     in   1       serial data from the ADC
//  adc_cnv     out  1       conversion start to the ADC
//  adc_sclk    out  1       serial clock to the ADC
//  x           out  DATA_W  last completed sample, held between strobes
//  data_valid  out  1       1-clk pulse: x updated this cycle
//  busy        out  1       acquisition in progress (state != IDLE)
//  overrun     out  1       sticky: a period tick fell while busy; cleared only by rst
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; adc_cnv=0; adc_sclk=0; x=0; data_valid=0;
//   busy=0; overrun=0; period counter=0; shift register=0.
//  Period counter: counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps; tick when count==0.
//   With enable=0 the counter is held at 0. On enable 0->1, the first tick is on the
//   first clk edge with enable high.
//  FSM:
//   IDLE  : on tick, go to CONV and raise adc_cnv.
//   CONV  : hold adc_cnv=1 for CONV_CYCLES clks, then drop it and go to SHIFT.
//   SHIFT : toggle adc_sclk every SCLK_DIV clks, starting low.
//           Sample adc_sdo in the clk where adc_sclk goes 0->1; shift it into the LSB.
//           After DATA_W rising edges, return adc_sclk to 0 and go to DONE.
//   DONE  : one clk. x <= shift register; data_valid=1; then go to IDLE.
//  Latency: tick -> data_valid = CONV_CYCLES + 2*SCLK_DIV*DATA_W + 1 clks.
//  enable dropped mid-acquisition: the current sample completes and is delivered;
//   no new tick occurs.
//  Tick while not IDLE: the tick is skipped and overrun is set.
//  x changes only in DONE; data_valid is never high two cycles in a row.
//  Mid-operation reset aborts the transfer at once: adc_cnv and adc_sclk fall
//   asynchronously, and no partial sample ever reaches x.
// CONFIGURATION
//  ADC_AVG_EN defined:
//   - Each completed sample is added to a DATA_W+2-bit accumulator.
//   - Every 4th sample, x <= accumulator>>2, truncated toward zero, and data_valid pulses.
//   - Then the accumulator clears.
//   - The strobe rate is 1/4 of the tick rate.
//   - The accumulator and the sample count reset to 0 on rst, and also while enable=0.
//  ADC_AVG_EN undefined: every sample goes straight to x. There is no accumulator logic.
// TESTING
//  1 Reset/idle: rst=0, then rst=1 with enable=0 for 1000 clks ->
//    all outputs 0, adc_cnv never rises.
//  2 Single sample: enable=1, ADC model returns 36'h9_A5A5_0F0F ->
//    adc_cnv high for 35 clks, then 36 sclk rising edges.
//    data_valid pulses 180 clks after the tick with x=36'h9_A5A5_0F0F.
//  3 Periodic: enable=1 for 2500 clks with a changing ADC model ->
//    exactly 10 data_valid pulses, 250 clks apart; overrun stays 0.
//  4 Overrun: SAMPLE_PERIOD=181 passes and 180 fails elaboration.
//    Force a stalled tick via the bench hook -> overrun=1 and stays 1 until rst.
//  5 Abort: pull rst low at the 20th sclk edge -> adc_sclk=0 and adc_cnv=0 immediately.
//    After release with enable=1, the next sample is delivered correctly.
//  6 ADC_AVG_EN: samples 100, 200, 300, 401 -> one data_valid after the 4th sample,
//    x=250; no strobe for samples 1-3.

Source files
------------

// File: rtl/adc_sample_acq.sv
// adc_sample_acq: periodic serial-ADC acquisition front end.
// Triggers a conversion every SAMPLE_PERIOD clks. It holds adc_cnv high for
// CONV_CYCLES clks, then clocks DATA_W bits in MSB first on adc_sclk. The
// finished sample is published on x together with a one-clk data_valid strobe.
// Optional build macro: ADC_AVG_EN. When it is defined, x carries the mean of
// every four consecutive samples, and the strobe fires once per four samples.
`timescale 1ns/1ps
module adc_sample_acq #(
  parameter int DATA_W        = 36,
  parameter int SCLK_DIV      = 2,
  parameter int CONV_CYCLES   = 35,
  parameter int SAMPLE_PERIOD = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_sdo,
  output logic              adc_cnv,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] x,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int DIV_W  = $clog2(SCLK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  // A period shorter than one full acquisition plus the DONE and IDLE clks
  // would make every tick collide with a busy FSM.
  generate
    if (SAMPLE_PERIOD < CONV_CYCLES + 2 * SCLK_DIV * DATA_W + 2) begin : g_bad_period
      $error("adc_sample_acq: SAMPLE_PERIOD too short for one acquisition");
    end
    if (SCLK_DIV < 1 || CONV_CYCLES < 1 || DATA_W < 2) begin : g_bad_timing
      $error("adc_sample_acq: SCLK_DIV, CONV_CYCLES must be >= 1, DATA_W >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [PER_W-1:0]    period_cnt_reg;
  logic [CONV_W-1:0]   conv_cnt_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic                sclk_reg;
  logic                cnv_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   x_reg;
  logic                valid_reg;
  logic                overrun_reg;

  logic tick;
  logic conv_last;
  logic sclk_toggle;
  logic shift_last;

  assign tick        = enable && (period_cnt_reg == '0);
  assign conv_last   = (conv_cnt_reg == CONV_W'(CONV_CYCLES - 1));
  assign sclk_toggle = (div_cnt_reg == DIV_W'(SCLK_DIV - 1));
  // The last falling sclk edge, after all DATA_W rising edges have been seen.
  assign shift_last  = sclk_toggle && sclk_reg && (bit_cnt_reg == BIT_W'(DATA_W));

  assign adc_cnv    = cnv_reg;
  assign adc_sclk   = sclk_reg;
  assign x          = x_reg;
  assign data_valid = valid_reg;
  assign busy       = (state_reg != IDLE);
  assign overrun    = overrun_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick)       state_next = CONV;
      CONV:    if (conv_last)  state_next = SHIFT;
      SHIFT:   if (shift_last) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Free-running period counter. It is held at zero while disabled, so the
  // first enabled edge ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt_reg <= '0;
    end else if (!enable) begin
      period_cnt_reg <= '0;
    end else if (period_cnt_reg == PER_W'(SAMPLE_PERIOD - 1)) begin
      period_cnt_reg <= '0;
    end else begin
      period_cnt_reg <= period_cnt_reg + PER_W'(1);
    end
  end

  // Conversion pulse. adc_cnv is registered from the next state, so it rises
  // on the tick edge and falls on the edge that leaves CONV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnv_reg      <= 1'b0;
      conv_cnt_reg <= '0;
    end else begin
      cnv_reg      <= (state_next == CONV);
      conv_cnt_reg <= (state_reg == CONV) ? conv_cnt_reg + CONV_W'(1) : '0;
    end
  end

  // Serial clock generator and shifter. sdo is captured on the clk edge
  // that drives sclk high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_reg    <= 1'b0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (state_reg == SHIFT) begin
      if (sclk_toggle) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
        if (!sclk_reg) begin
          bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          shift_reg   <= {shift_reg[DATA_W-2:0], adc_sdo};
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end else begin
      sclk_reg    <= 1'b0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end
  end

`ifdef ADC_AVG_EN
  logic [DATA_W+1:0] acc_reg;
  logic [1:0]        avg_cnt_reg;
  logic [DATA_W+1:0] acc_sum;

  assign acc_sum = acc_reg + {2'b00, shift_reg};

  // Publish the mean of four samples. Partial groups are discarded while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg       <= '0;
      valid_reg   <= 1'b0;
      acc_reg     <= '0;
      avg_cnt_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (!enable) begin
        acc_reg     <= '0;
        avg_cnt_reg <= '0;
      end else if (state_reg == DONE) begin
        if (avg_cnt_reg == 2'd3) begin
          x_reg       <= DATA_W'(acc_sum >> 2);
          valid_reg   <= 1'b1;
          acc_reg     <= '0;
          avg_cnt_reg <= '0;
        end else begin
          acc_reg     <= acc_sum;
          avg_cnt_reg <= avg_cnt_reg + 2'd1;
        end
      end
    end
  end
`else
  // Publish each completed sample directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == DONE) begin
        x_reg     <= shift_reg;
        valid_reg <= 1'b1;
      end
    end
  end
`endif

  // Sticky flag for a period tick that arrived while an acquisition was still running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           overrun_reg <= 1'b0;
    else if (tick && state_reg != IDLE) overrun_reg <= 1'b1;
  end

endmodule
